// File: rtl/reg_dump_unit.sv
// Register-file dump engine: streams regs[first..last] (wrapping) as valid/ready bytes with a running checksum.
// Two cycles per byte (READ then SEND); OutData/OutLast hold in SEND until OutReady, which is ignored elsewhere.
module reg_dump_unit #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] FirstAddr,
  input  logic [ADDR_W-1:0] LastAddr,
  output logic [ADDR_W-1:0] Raddr,
  input  logic [DATA_W-1:0] RdData,
  output logic [DATA_W-1:0] OutData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              OutLast,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Checksum
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] checksum;
  logic              at_last;

  assign at_last  = (addr_cnt == last_addr);
  assign Raddr    = addr_cnt;
  assign OutData  = out_data;
  assign OutValid = (state == S_SEND);
  assign OutLast  = (state == S_SEND) && at_last;
  assign Busy     = (state != S_IDLE);
  assign Done     = (state == S_DONE);
  assign Checksum = checksum;

  // The start address lives only in the counter; only the end address needs to be kept.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      addr_cnt  <= '0;
      last_addr <= '0;
      out_data  <= '0;
      checksum  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            addr_cnt  <= FirstAddr;
            last_addr <= LastAddr;
            checksum  <= '0;
            state     <= S_READ;
          end
        end
        S_READ: begin
          out_data <= RdData;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (OutReady) begin
            checksum <= checksum + out_data;
            if (at_last) begin
              state <= S_DONE;
            end else begin
              addr_cnt <= addr_cnt + ADDR_W'(1);
              state    <= S_READ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
